alu_core: RTL and testbench

//  Registered 6502 ALU stage fed by the ALU input mux: operand B is the mux output, operand A is the accumulator.

---
 rtl/alu_pkg.sv | 39 +++
 rtl/alu_bcd_adjust.sv | 51 +++++
 rtl/alu_core.sv | 240 ++++++++++++++++++++++++
 tb/tb_alu_core.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : alu_pkg
//  Description : Shared definitions for the 6502 ALU stage: operation codes,
//                FSM state encoding and flag bit positions within {N,V,Z,C}.
//  Revision    : 1.0 - initial release
// ============================================================================
package alu_pkg;

    // Operation codes carried on alu_op. Codes 14 and 15 are undefined and
    // behave as PASS with no flag updates.
    localparam logic [3:0] ALU_OP_ADC  = 4'd0;
    localparam logic [3:0] ALU_OP_SBC  = 4'd1;
    localparam logic [3:0] ALU_OP_CMP  = 4'd2;
    localparam logic [3:0] ALU_OP_AND  = 4'd3;
    localparam logic [3:0] ALU_OP_ORA  = 4'd4;
    localparam logic [3:0] ALU_OP_EOR  = 4'd5;
    localparam logic [3:0] ALU_OP_BIT  = 4'd6;
    localparam logic [3:0] ALU_OP_ASL  = 4'd7;
    localparam logic [3:0] ALU_OP_LSR  = 4'd8;
    localparam logic [3:0] ALU_OP_ROL  = 4'd9;
    localparam logic [3:0] ALU_OP_ROR  = 4'd10;
    localparam logic [3:0] ALU_OP_INC  = 4'd11;
    localparam logic [3:0] ALU_OP_DEC  = 4'd12;
    localparam logic [3:0] ALU_OP_PASS = 4'd13;

    // Bit positions of each flag inside the 4-bit flags / flags_upd vectors.
    localparam int FLG_N = 3;
    localparam int FLG_V = 2;
    localparam int FLG_Z = 1;
    localparam int FLG_C = 0;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_ADJ  = 1'b1
    } alu_state_e;

endpackage
`default_nettype wire

// File: rtl/alu_bcd_adjust.sv
`default_nettype none
// ============================================================================
//  Module      : alu_bcd_adjust
//  Description : Combinational 65C02-style BCD correction applied to the
//                binary sum produced in the first cycle of decimal ADC/SBC.
//  Ports       : sum_i         binary 8-bit sum (SBC: a + ~b + c)
//                carry_i       binary carry out of bit 7 (SBC: no borrow)
//                half_carry_i  binary carry out of bit 3 (SBC: no half borrow)
//                is_sub_i      1 for SBC, 0 for ADC
//                adj_result_o  BCD-corrected result
//                adj_carry_o   decimal carry (SBC: no decimal borrow)
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_bcd_adjust (
    input  logic [7:0] sum_i,
    input  logic       carry_i,
    input  logic       half_carry_i,
    input  logic       is_sub_i,
    output logic [7:0] adj_result_o,
    output logic       adj_carry_o
);

    logic       lo_fix;
    logic       hi_fix;
    logic [7:0] lo_val;
    logic [7:0] hi_val;

    always_comb begin
        if (is_sub_i) begin
            // Borrow out of a nibble means that digit wrapped past zero.
            lo_fix = ~half_carry_i;
            hi_fix = ~carry_i;
        end else begin
            // High-digit test uses the unadjusted sum, so a low-digit
            // overflow that would push the upper digit past 9 is caught here.
            lo_fix = (sum_i[3:0] > 4'd9) | half_carry_i;
            hi_fix = (sum_i > 8'h99) | carry_i;
        end
        lo_val = lo_fix ? 8'h06 : 8'h00;
        hi_val = hi_fix ? 8'h60 : 8'h00;
        if (is_sub_i) begin
            adj_result_o = sum_i - lo_val - hi_val;
            adj_carry_o  = carry_i;
        end else begin
            adj_result_o = sum_i + lo_val + hi_val;
            adj_carry_o  = hi_fix;
        end
    end

endmodule
`default_nettype wire

// File: rtl/alu_core.sv
`default_nettype none
// ============================================================================
//  Module      : alu_core
//  Description : Registered 6502 ALU stage. Binary ops complete in one cycle;
//                decimal ADC/SBC take a second (BCD adjust) cycle.
//  Ports       : clk, rst_n          clock, async active-low reset
//                start_i             op request, ignored while busy
//                alu_op_i            operation code (alu_pkg)
//                a_in_i / b_in_i     accumulator / ALU input mux operands
//                carry_in_i          P.C
//                decimal_en_i        P.D, used by ADC/SBC only
//                result_o / flags_o  registered result and {N,V,Z,C}
//                flags_upd_o         flags defined by the completed op
//                res_we_o            result targets a register
//                valid_o             one-cycle pulse for fresh outputs
//                busy_o              high during the decimal adjust cycle
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_core
    import alu_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int OP_W  = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_i,
    input  logic [OP_W-1:0]  alu_op_i,
    input  logic [WIDTH-1:0] a_in_i,
    input  logic [WIDTH-1:0] b_in_i,
    input  logic             carry_in_i,
    input  logic             decimal_en_i,
    output logic [WIDTH-1:0] result_o,
    output logic [3:0]       flags_o,
    output logic [3:0]       flags_upd_o,
    output logic             res_we_o,
    output logic             valid_o,
    output logic             busy_o
);

    alu_state_e       state_q, state_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [3:0]       flags_q, flags_d;
    logic [3:0]       flags_upd_q, flags_upd_d;
    logic             res_we_q, res_we_d;
    logic             valid_q, valid_d;
    logic             busy_q, busy_d;
    // Binary-cycle results held for the adjust cycle.
    logic [7:0]       sum_q, sum_d;
    logic             carry_q, carry_d;
    logic             half_q, half_d;
    logic             sub_q, sub_d;
    logic             v_q, v_d;

    // ---------------- binary datapath ----------------
    logic [7:0] b_eff;
    logic [8:0] sum9;
    logic [4:0] half5;
    logic [8:0] cmp9;
    logic       add_v;
    logic       is_dec;
    logic [7:0] bin_res;
    logic       bin_n, bin_v, bin_c;
    logic [3:0] bin_mask;
    logic       bin_we;
    logic [3:0] bin_flags;
    logic [7:0] adj_res;
    logic       adj_c;

    assign b_eff  = (alu_op_i == ALU_OP_SBC) ? ~b_in_i : b_in_i;
    assign sum9   = {1'b0, a_in_i} + {1'b0, b_eff} + {8'd0, carry_in_i};
    assign half5  = {1'b0, a_in_i[3:0]} + {1'b0, b_eff[3:0]} + {4'd0, carry_in_i};
    assign cmp9   = {1'b0, a_in_i} + {1'b0, ~b_in_i} + 9'd1;
    assign add_v  = ~(a_in_i[7] ^ b_eff[7]) & (a_in_i[7] ^ sum9[7]);
    assign is_dec = decimal_en_i &
                    ((alu_op_i == ALU_OP_ADC) | (alu_op_i == ALU_OP_SBC));

    always_comb begin
        bin_res  = b_in_i;
        bin_c    = 1'b0;
        bin_v    = 1'b0;
        bin_mask = 4'b1010;
        bin_we   = 1'b1;
        unique case (alu_op_i)
            ALU_OP_ADC, ALU_OP_SBC: begin
                bin_res  = sum9[7:0];
                bin_c    = sum9[8];
                bin_v    = add_v;
                bin_mask = 4'b1111;
            end
            ALU_OP_CMP: begin
                bin_res  = cmp9[7:0];
                bin_c    = cmp9[8];
                bin_mask = 4'b1011;
                bin_we   = 1'b0;
            end
            ALU_OP_AND: bin_res = a_in_i & b_in_i;
            ALU_OP_ORA: bin_res = a_in_i | b_in_i;
            ALU_OP_EOR: bin_res = a_in_i ^ b_in_i;
            ALU_OP_BIT: begin
                bin_res  = a_in_i & b_in_i;
                bin_v    = b_in_i[6];
                bin_mask = 4'b1110;
                bin_we   = 1'b0;
            end
            ALU_OP_ASL: begin
                bin_res  = {b_in_i[6:0], 1'b0};
                bin_c    = b_in_i[7];
                bin_mask = 4'b1011;
            end
            ALU_OP_LSR: begin
                bin_res  = {1'b0, b_in_i[7:1]};
                bin_c    = b_in_i[0];
                bin_mask = 4'b1011;
            end
            ALU_OP_ROL: begin
                bin_res  = {b_in_i[6:0], carry_in_i};
                bin_c    = b_in_i[7];
                bin_mask = 4'b1011;
            end
            ALU_OP_ROR: begin
                bin_res  = {carry_in_i, b_in_i[7:1]};
                bin_c    = b_in_i[0];
                bin_mask = 4'b1011;
            end
            ALU_OP_INC:  bin_res = b_in_i + 8'd1;
            ALU_OP_DEC:  bin_res = b_in_i - 8'd1;
            ALU_OP_PASS: bin_res = b_in_i;
            default:     bin_mask = 4'b0000;
        endcase
        // BIT takes N from the operand rather than the AND result.
        bin_n = (alu_op_i == ALU_OP_BIT) ? b_in_i[7] : bin_res[7];

        bin_flags        = 4'b0000;
        bin_flags[FLG_N] = bin_n;
        bin_flags[FLG_V] = bin_v;
        bin_flags[FLG_Z] = (bin_res == 8'd0);
        bin_flags[FLG_C] = bin_c;
        bin_flags        = bin_flags & bin_mask;
    end

    alu_bcd_adjust u_bcd_adjust (
        .sum_i        (sum_q),
        .carry_i      (carry_q),
        .half_carry_i (half_q),
        .is_sub_i     (sub_q),
        .adj_result_o (adj_res),
        .adj_carry_o  (adj_c)
    );

    // ---------------- FSM and output update ----------------
    always_comb begin
        state_d     = state_q;
        result_d    = result_q;
        flags_d     = flags_q;
        flags_upd_d = flags_upd_q;
        res_we_d    = res_we_q;
        valid_d     = 1'b0;
        busy_d      = 1'b0;
        sum_d       = sum_q;
        carry_d     = carry_q;
        half_d      = half_q;
        sub_d       = sub_q;
        v_d         = v_q;
        unique case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    if (is_dec) begin
                        state_d = ST_ADJ;
                        busy_d  = 1'b1;
                        sum_d   = sum9[7:0];
                        carry_d = sum9[8];
                        half_d  = half5[4];
                        sub_d   = (alu_op_i == ALU_OP_SBC);
                        v_d     = add_v;
                    end else begin
                        result_d    = bin_res;
                        flags_d     = bin_flags;
                        flags_upd_d = bin_mask;
                        res_we_d    = bin_we;
                        valid_d     = 1'b1;
                    end
                end
            end
            ST_ADJ: begin
                // start is deliberately ignored here, not queued.
                state_d          = ST_IDLE;
                result_d         = adj_res;
                flags_d          = 4'b0000;
                flags_d[FLG_N]   = adj_res[7];
                flags_d[FLG_V]   = v_q;
                flags_d[FLG_Z]   = (adj_res == 8'd0);
                flags_d[FLG_C]   = adj_c;
                flags_upd_d      = 4'b1111;
                res_we_d         = 1'b1;
                valid_d          = 1'b1;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            result_q    <= '0;
            flags_q     <= 4'b0000;
            flags_upd_q <= 4'b0000;
            res_we_q    <= 1'b0;
            valid_q     <= 1'b0;
            busy_q      <= 1'b0;
            sum_q       <= 8'd0;
            carry_q     <= 1'b0;
            half_q      <= 1'b0;
            sub_q       <= 1'b0;
            v_q         <= 1'b0;
        end else begin
            state_q     <= state_d;
            result_q    <= result_d;
            flags_q     <= flags_d;
            flags_upd_q <= flags_upd_d;
            res_we_q    <= res_we_d;
            valid_q     <= valid_d;
            busy_q      <= busy_d;
            sum_q       <= sum_d;
            carry_q     <= carry_d;
            half_q      <= half_d;
            sub_q       <= sub_d;
            v_q         <= v_d;
        end
    end

    assign result_o    = result_q;
    assign flags_o     = flags_q;
    assign flags_upd_o = flags_upd_q;
    assign res_we_o    = res_we_q;
    assign valid_o     = valid_q;
    assign busy_o      = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_core.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alu_core
//  Description : Self-checking bench for alu_core with an arithmetic reference
//                model, directed corner cases and randomized op streams.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_core;
    import alu_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [3:0] alu_op;
    logic [7:0] a_in, b_in;
    logic       carry_in, decimal_en;
    logic [7:0] result;
    logic [3:0] flags, flags_upd;
    logic       res_we, valid, busy;

    always #5 clk = ~clk;

    alu_core #(.WIDTH(8), .OP_W(4)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start_i      (start),
        .alu_op_i     (alu_op),
        .a_in_i       (a_in),
        .b_in_i       (b_in),
        .carry_in_i   (carry_in),
        .decimal_en_i (decimal_en),
        .result_o     (result),
        .flags_o      (flags),
        .flags_upd_o  (flags_upd),
        .res_we_o     (res_we),
        .valid_o      (valid),
        .busy_o       (busy)
    );

    typedef struct {
        int         due;
        logic [7:0] res;
        logic [3:0] fl;     // {N,V,Z,C} already masked
        logic [3:0] mask;
        logic       we;
        logic       chk_res;
        logic       dec;
    } exp_t;

    exp_t q[$];
    int   cyc    = 0;
    int   errors = 0;
    int   checks = 0;
    int   dec_e  = -10;     // edge at which the last decimal op was accepted

    logic [7:0] last_res;
    logic       last_res_ok;
    logic [3:0] last_fl, last_mask;
    logic       last_we;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int bcd2int(input logic [7:0] x);
        return int'(x[7:4]) * 10 + int'(x[3:0]);
    endfunction

    function automatic logic [7:0] int2bcd(input int v);
        logic [7:0] r;
        r[7:4] = 4'(v / 10);
        r[3:0] = 4'(v % 10);
        return r;
    endfunction

    // Reference model: what the op must produce, from plain arithmetic.
    function automatic exp_t model(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                                   input logic c, input logic d);
        exp_t m;
        int   ia, ib, ic, s, sv;
        logic n, v, z, cf;
        logic [7:0] bb;
        ia = int'(a); ib = int'(b); ic = int'(c);
        m.res = b; m.mask = 4'b1010; m.we = 1'b1; m.chk_res = 1'b1; m.dec = 1'b0; m.due = 0;
        v = 1'b0; cf = 1'b0;
        n = 1'b0;
        case (op)
            ALU_OP_ADC, ALU_OP_SBC: begin
                bb = (op == ALU_OP_SBC) ? ~b : b;
                s  = ia + int'(bb) + ic;
                sv = int'($signed(a)) + int'($signed(bb)) + ic;
                v  = (sv > 127) || (sv < -128);
                m.mask = 4'b1111;
                if (d) begin
                    m.dec = 1'b1;
                    if (op == ALU_OP_ADC) s = bcd2int(a) + bcd2int(b) + ic;
                    else                  s = bcd2int(a) - bcd2int(b) - (1 - ic);
                    if (op == ALU_OP_ADC) begin cf = (s >= 100); s = s % 100; end
                    else begin cf = (s >= 0); if (s < 0) s = s + 100; end
                    m.res = int2bcd(s);
                end else begin
                    m.res = s[7:0];
                    cf    = (s > 255);
                end
            end
            ALU_OP_CMP: begin
                s = ia - ib; m.res = s[7:0]; cf = (ia >= ib); m.mask = 4'b1011; m.we = 1'b0;
            end
            ALU_OP_AND: m.res = a & b;
            ALU_OP_ORA: m.res = a | b;
            ALU_OP_EOR: m.res = a ^ b;
            ALU_OP_BIT: begin m.chk_res = 1'b0; m.mask = 4'b1110; m.we = 1'b0; v = b[6]; end
            ALU_OP_ASL: begin s = ib * 2;             m.res = s[7:0]; cf = (ib >= 128); m.mask = 4'b1011; end
            ALU_OP_LSR: begin s = ib / 2;             m.res = s[7:0]; cf = (ib % 2 == 1); m.mask = 4'b1011; end
            ALU_OP_ROL: begin s = ib * 2 + ic;        m.res = s[7:0]; cf = (ib >= 128); m.mask = 4'b1011; end
            ALU_OP_ROR: begin s = ib / 2 + ic * 128;  m.res = s[7:0]; cf = (ib % 2 == 1); m.mask = 4'b1011; end
            ALU_OP_INC: begin s = (ib + 1) % 256;     m.res = s[7:0]; end
            ALU_OP_DEC: begin s = (ib + 255) % 256;   m.res = s[7:0]; end
            ALU_OP_PASS: m.res = b;
            default:     m.mask = 4'b0000;
        endcase
        if (op == ALU_OP_BIT) begin
            n = b[7]; z = ((a & b) == 8'd0);
        end else begin
            n = (m.res >= 8'h80); z = (m.res == 8'd0);
        end
        m.fl = {n, v, z, cf} & m.mask;
        return m;
    endfunction

    // Per-cycle compare against the expected-event queue.
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            q.delete();
            last_res = 8'd0; last_res_ok = 1'b1; last_fl = 4'd0; last_mask = 4'd0; last_we = 1'b0;
            chk("rst_result", result, 0);
            chk("rst_flags", flags, 0);
            chk("rst_flags_upd", flags_upd, 0);
            chk("rst_res_we", res_we, 0);
            chk("rst_valid", valid, 0);
            chk("rst_busy", busy, 0);
        end else if (q.size() > 0 && q[0].due == cyc) begin
            e = q.pop_front();
            chk("valid", valid, 1);
            chk("busy_at_valid", busy, 0);
            if (e.chk_res) chk("result", result, e.res);
            chk("flags", flags & e.mask, e.fl);
            chk("flags_upd", flags_upd, e.mask);
            chk("res_we", res_we, e.we);
            last_res = e.res; last_res_ok = e.chk_res; last_fl = e.fl; last_mask = e.mask; last_we = e.we;
        end else begin
            chk("no_valid", valid, 0);
            chk("busy", busy, (cyc == dec_e) ? 1 : 0);
            if (last_res_ok) chk("hold_result", result, last_res);
            chk("hold_flags", flags & last_mask, last_fl);
            chk("hold_flags_upd", flags_upd, last_mask);
            chk("hold_res_we", res_we, last_we);
        end
    end

    task automatic step(input logic s, input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                        input logic c, input logic d);
        exp_t m;
        int   e;
        @(negedge clk); #1;
        start = s; alu_op = op; a_in = a; b_in = b; carry_in = c; decimal_en = d;
        e = cyc + 1;
        if (s && (e != dec_e + 1)) begin
            m = model(op, a, b, c, d);
            m.due = m.dec ? e + 1 : e;
            q.push_back(m);
            if (m.dec) dec_e = e;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, ALU_OP_PASS, $urandom_range(0, 255), $urandom_range(0, 255), 1'b0, 1'b0);
    endtask

    task automatic pulse_reset();
        @(negedge clk); #1;
        rst_n = 1'b0; start = 1'b0; dec_e = -10;
        @(negedge clk); #1;
        rst_n = 1'b1;
    endtask

    task automatic pin(input string name, input exp_t m, input logic [7:0] res, input logic [3:0] fl);
        chk({name, "_res"}, m.res, res);
        chk({name, "_fl"}, m.fl, fl);
    endtask

    initial begin
        exp_t m;
        logic [3:0] op;
        logic [7:0] a, b;
        logic       d;
        rst_n = 1'b0; start = 1'b0; alu_op = 4'd0; a_in = 8'd0; b_in = 8'd0;
        carry_in = 1'b0; decimal_en = 1'b0;

        // Hand-computed values that pin the reference model.
        m = model(ALU_OP_ADC, 8'h50, 8'h50, 1'b0, 1'b0); pin("pin_adc", m, 8'hA0, 4'b1100);
        m = model(ALU_OP_ADC, 8'h58, 8'h46, 1'b1, 1'b1); pin("pin_dadc", m, 8'h05, 4'b0101);
        m = model(ALU_OP_SBC, 8'h40, 8'h13, 1'b1, 1'b1); pin("pin_dsbc", m, 8'h27, 4'b0001);
        m = model(ALU_OP_SBC, 8'h00, 8'h01, 1'b1, 1'b1); pin("pin_dsbc0", m, 8'h99, 4'b1000);
        m = model(ALU_OP_CMP, 8'h10, 8'h20, 1'b0, 1'b0); pin("pin_cmp", m, 8'hF0, 4'b1000);
        chk("pin_cmp_mask", m.mask, 4'b1011);
        m = model(ALU_OP_ROR, 8'h00, 8'h01, 1'b1, 1'b0); pin("pin_ror", m, 8'h80, 4'b1001);
        m = model(ALU_OP_INC, 8'h00, 8'hFF, 1'b0, 1'b0); pin("pin_inc", m, 8'h00, 4'b0010);
        chk("pin_inc_mask", m.mask, 4'b1010);

        repeat (3) @(negedge clk);
        #1 rst_n = 1'b1;

        // Directed cases.
        step(1, ALU_OP_ADC, 8'h50, 8'h50, 0, 0); idle(2);
        step(1, ALU_OP_ADC, 8'h58, 8'h46, 1, 1); idle(3);
        step(1, ALU_OP_SBC, 8'h40, 8'h13, 1, 1); idle(2);
        step(1, ALU_OP_SBC, 8'h00, 8'h01, 1, 1); idle(2);
        step(1, ALU_OP_CMP, 8'h10, 8'h20, 0, 0);
        step(1, ALU_OP_ROR, 8'h00, 8'h01, 1, 1);
        step(1, ALU_OP_INC, 8'h00, 8'hFF, 1, 0);
        step(1, ALU_OP_DEC, 8'h00, 8'h00, 1, 0);
        step(1, ALU_OP_BIT, 8'h0F, 8'hC0, 0, 0);
        step(1, 4'd15,      8'h00, 8'h5A, 0, 0); idle(2);
        // Start again during ADJ must be dropped.
        step(1, ALU_OP_ADC, 8'h19, 8'h01, 0, 1);
        step(1, ALU_OP_PASS, 8'h00, 8'h77, 0, 0); idle(3);
        // Reset during ADJ: no valid, outputs cleared.
        step(1, ALU_OP_ADC, 8'h58, 8'h46, 1, 1);
        pulse_reset(); idle(3);

        // Randomized stream, including starts during ADJ and operand churn.
        for (int i = 0; i < 600; i++) begin
            op = 4'($urandom_range(0, 15));
            d  = 1'($urandom_range(0, 1));
            if ((op == ALU_OP_ADC || op == ALU_OP_SBC) && d) begin
                a = {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
                b = {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
            end else begin
                a = 8'($urandom_range(0, 255));
                b = 8'($urandom_range(0, 255));
            end
            step(($urandom_range(0, 9) < 7), op, a, b, 1'($urandom_range(0, 1)), d);
            if ($urandom_range(0, 199) == 0) pulse_reset();
        end
        idle(4);
        chk("queue_drained", q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
